// File: rtl/sram_pkg.sv
// Shared types and constants for the sram_word_array slice.
// Optional parity storage is controlled by the SRAM_PARITY_EN macro.
package sram_pkg;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    WRITE = 2'd2,
    READ  = 2'd3
  } sram_state_t;

  localparam logic R_W_WRITE = 1'b1;

endpackage

// File: rtl/sram_word_array_if.sv
// Request/response bus between the memory controller (master) and sram_word_array (slave).
// The perr response exists only when SRAM_PARITY_EN is defined.
interface sram_word_array_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);

  logic              sel;
  logic              r_w;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] in;
  logic              busy;
  logic [DATA_W-1:0] out;
  logic              out_valid;
  logic              addr_err;
`ifdef SRAM_PARITY_EN
  logic              perr;
`endif

  modport master (
    output sel, r_w, addr, in,
    input  busy, out, out_valid, addr_err
`ifdef SRAM_PARITY_EN
    , input perr
`endif
  );

  modport slave (
    input  sel, r_w, addr, in,
    output busy, out, out_valid, addr_err
`ifdef SRAM_PARITY_EN
    , output perr
`endif
  );

endinterface

// File: rtl/sram_row.sv
// One storage word: loads d on a clock edge with we=1, otherwise holds.
module sram_row #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // NOTE: storage has no reset; its contents are defined by the CLEAR sweep instead.
  always_ff @(posedge clk) begin
    if (we) q <= d;
  end

endmodule

// File: rtl/sram_word_array.sv
// DEPTH x DATA_W word array with FSM-sequenced access, busy handshake and post-reset clear.
// Define SRAM_PARITY_EN to store an even-parity bit per word and report perr on reads.
module sram_word_array
  import sram_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input logic              clk,
  input logic              rst_n,
  sram_word_array_if.slave bus
);

`ifdef SRAM_PARITY_EN
  localparam int WORD_W = DATA_W + 1;
`else
  localparam int WORD_W = DATA_W;
`endif

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_V  = (ADDR_W + 1)'(DEPTH);

  sram_state_t       state_q, state_d;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] out_q;
  logic              out_valid_q;
  logic              addr_err_q;
  logic              accept;

  logic [WORD_W-1:0] word_q [DEPTH];
  logic [DEPTH-1:0]  row_we;
  logic [WORD_W-1:0] wr_word;
  logic [WORD_W-1:0] wr_data_word;
  logic [WORD_W-1:0] rd_word;

  assign accept = (state_q == IDLE) && bus.sel;

`ifdef SRAM_PARITY_EN
  logic perr_q;
  assign wr_data_word = {^data_q, data_q};
  assign bus.perr     = perr_q;
`else
  assign wr_data_word = data_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CLEAR:   if (ptr_q == LAST_PTR) state_d = IDLE;
      IDLE:    if (bus.sel) state_d = (bus.r_w == R_W_WRITE) ? WRITE : READ;
      WRITE:   state_d = IDLE;
      READ:    state_d = IDLE;
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      addr_err_q  <= 1'b0;
`ifdef SRAM_PARITY_EN
      perr_q      <= 1'b0;
`endif
    end else begin
      out_valid_q <= 1'b0;
      addr_err_q  <= 1'b0;
`ifdef SRAM_PARITY_EN
      perr_q      <= 1'b0;
`endif
      if (state_q == CLEAR) begin
        ptr_q <= (ptr_q == LAST_PTR) ? '0 : ptr_q + 1'b1;
      end
      // addr_err_q is high exactly for the WRITE/READ cycle of an out-of-range request.
      if (accept) begin
        addr_q     <= bus.addr;
        data_q     <= bus.in;
        addr_err_q <= ({1'b0, bus.addr} >= DEPTH_V);
      end
      if (state_q == READ) begin
        out_valid_q <= 1'b1;
        out_q       <= addr_err_q ? '0 : rd_word[DATA_W-1:0];
`ifdef SRAM_PARITY_EN
        perr_q      <= !addr_err_q && (^rd_word);
`endif
      end
    end
  end

  always_comb begin
    row_we  = '0;
    wr_word = '0;
    if (state_q == WRITE) wr_word = wr_data_word;
    for (int i = 0; i < DEPTH; i++) begin
      row_we[i] = ((state_q == CLEAR) && (ptr_q == ADDR_W'(i))) ||
                  ((state_q == WRITE) && !addr_err_q && (addr_q == ADDR_W'(i)));
    end
  end

  assign rd_word = addr_err_q ? '0 : word_q[addr_q];

  for (genvar g = 0; g < DEPTH; g++) begin : g_row
    sram_row #(.W(WORD_W)) u_row (
      .clk (clk),
      .we  (row_we[g]),
      .d   (wr_word),
      .q   (word_q[g])
    );
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.addr_err  = addr_err_q;

endmodule

// File: tb/tb_sram_word_array.sv
// Directed bench: a DEPTH=16 and a DEPTH=12 array driven by the same request stream.
// Parity corruption is exercised only when SRAM_PARITY_EN is defined.
module tb_sram_word_array;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sel = 1'b0;
  logic       r_w = 1'b0;
  logic [3:0] addr = '0;
  logic [7:0] din = '0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sram_word_array_if #(.DATA_W(8), .ADDR_W(4)) bus16 ();
  sram_word_array_if #(.DATA_W(8), .ADDR_W(4)) bus12 ();

  assign bus16.sel  = sel;
  assign bus16.r_w  = r_w;
  assign bus16.addr = addr;
  assign bus16.in   = din;
  assign bus12.sel  = sel;
  assign bus12.r_w  = r_w;
  assign bus12.addr = addr;
  assign bus12.in   = din;

  sram_word_array #(.DATA_W(8), .ADDR_W(4), .DEPTH(16)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16.slave)
  );

  sram_word_array #(.DATA_W(8), .ADDR_W(4), .DEPTH(12)) dut12 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus12.slave)
  );

  function automatic logic obs_busy(input bit b12);
    return b12 ? bus12.busy : bus16.busy;
  endfunction

  function automatic logic [7:0] obs_out(input bit b12);
    return b12 ? bus12.out : bus16.out;
  endfunction

  function automatic logic obs_valid(input bit b12);
    return b12 ? bus12.out_valid : bus16.out_valid;
  endfunction

  function automatic logic obs_err(input bit b12);
    return b12 ? bus12.addr_err : bus16.addr_err;
  endfunction

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 64 && (bus16.busy || bus12.busy); i++) @(negedge clk);
    if (bus16.busy || bus12.busy) check("idle_timeout", {30'd0, bus16.busy, bus12.busy}, 32'd0);
  endtask

  // Returns at the falling edge after acceptance, i.e. during the WRITE/READ cycle.
  task automatic issue(input logic rw, input logic [3:0] a, input logic [7:0] d);
    wait_idle();
    r_w  = rw;
    addr = a;
    din  = d;
    sel  = 1'b1;
    @(negedge clk);
    sel  = 1'b0;
  endtask

  task automatic read_chk(input bit b12, input logic [3:0] a, input logic [7:0] exp_data,
                          input logic exp_err, input logic exp_perr, input string tag);
    issue(1'b0, a, 8'h00);
    check({tag, "_err"}, {31'd0, obs_err(b12)}, {31'd0, exp_err});
    check({tag, "_early"}, {31'd0, obs_valid(b12)}, 32'd0);
    @(negedge clk);
    check({tag, "_valid"}, {31'd0, obs_valid(b12)}, 32'd1);
    check({tag, "_data"}, {24'd0, obs_out(b12)}, {24'd0, exp_data});
`ifdef SRAM_PARITY_EN
    check({tag, "_perr"}, {31'd0, (b12 ? bus12.perr : bus16.perr)}, {31'd0, exp_perr});
`else
    if (exp_perr) check({tag, "_perr_unsupported"}, {31'd0, obs_valid(b12)}, 32'd0);
`endif
    @(negedge clk);
    check({tag, "_pulse"}, {31'd0, obs_valid(b12)}, 32'd0);
  endtask

  task automatic count_clear(output int c16, output int c12);
    c16 = 0;
    c12 = 0;
    for (int i = 0; i < 40; i++) begin
      if (!bus16.busy && !bus12.busy) break;
      if (bus16.busy) c16++;
      if (bus12.busy) c12++;
      @(negedge clk);
    end
  endtask

  initial begin
    int c16;
    int c12;
    logic [7:0] exp12;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, bus16.busy}, 32'd1);
    check("rst_out", {24'd0, bus16.out}, 32'd0);
    check("rst_valid", {31'd0, bus16.out_valid}, 32'd0);
    check("rst_err", {31'd0, bus16.addr_err}, 32'd0);
`ifdef SRAM_PARITY_EN
    check("rst_perr", {31'd0, bus16.perr}, 32'd0);
`endif

    // Clear sweep length and cleared contents
    rst_n = 1'b1;
    count_clear(c16, c12);
    check("clear_cycles16", c16, 32'd16);
    check("clear_cycles12", c12, 32'd12);
    for (int i = 0; i < 16; i++) read_chk(1'b0, 4'(i), 8'h00, 1'b0, 1'b0, $sformatf("clr%0d", i));

    // Write then read back with exact latency
    issue(1'b1, 4'd3, 8'hA5);
    check("wr3_busy", {31'd0, obs_busy(1'b0)}, 32'd1);
    check("wr3_err", {31'd0, obs_err(1'b0)}, 32'd0);
    read_chk(1'b0, 4'd3, 8'hA5, 1'b0, 1'b0, "rd3");

    // Read presented while busy is dropped
    issue(1'b1, 4'd5, 8'h3C);
    r_w  = 1'b0;
    addr = 4'd5;
    sel  = 1'b1;
    check("drop_busy", {31'd0, obs_busy(1'b0)}, 32'd1);
    @(negedge clk);
    sel = 1'b0;
    check("drop_valid0", {31'd0, obs_valid(1'b0)}, 32'd0);
    check("drop_idle", {31'd0, obs_busy(1'b0)}, 32'd0);
    @(negedge clk);
    check("drop_valid1", {31'd0, obs_valid(1'b0)}, 32'd0);
    check("drop_out_held", {24'd0, obs_out(1'b0)}, 32'h0000_00A5);
    read_chk(1'b0, 4'd5, 8'h3C, 1'b0, 1'b0, "rd5");

    // Out-of-range access on the 12-word array
    issue(1'b1, 4'd13, 8'hFF);
    check("oor_wr_err12", {31'd0, obs_err(1'b1)}, 32'd1);
    check("oor_wr_err16", {31'd0, obs_err(1'b0)}, 32'd0);
    @(negedge clk);
    check("oor_wr_pulse", {31'd0, obs_err(1'b1)}, 32'd0);
    for (int i = 0; i < 12; i++) begin
      exp12 = (i == 3) ? 8'hA5 : (i == 5) ? 8'h3C : 8'h00;
      read_chk(1'b1, 4'(i), exp12, 1'b0, 1'b0, $sformatf("d12_%0d", i));
    end
    read_chk(1'b1, 4'd3, 8'hA5, 1'b0, 1'b0, "d12_pre");
    read_chk(1'b1, 4'd13, 8'h00, 1'b1, 1'b0, "d12_oor");
    read_chk(1'b0, 4'd13, 8'hFF, 1'b0, 1'b0, "d16_13");

    // Reset during a WRITE aborts it and restarts the sweep
    issue(1'b1, 4'd7, 8'h11);
    check("abort_in_write", {31'd0, obs_busy(1'b0)}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_out_rst", {24'd0, obs_out(1'b0)}, 32'd0);
    check("abort_busy_rst", {31'd0, obs_busy(1'b0)}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    count_clear(c16, c12);
    check("reclear_cycles16", c16, 32'd16);
    read_chk(1'b0, 4'd7, 8'h00, 1'b0, 1'b0, "abort_rd7");
    read_chk(1'b0, 4'd3, 8'h00, 1'b0, 1'b0, "abort_rd3");

`ifdef SRAM_PARITY_EN
    // Corrupt stored bit 0 of word 2 (0x01, parity 1) and read it back
    issue(1'b1, 4'd2, 8'h01);
    wait_idle();
    force dut16.g_row[2].u_row.q = 9'h100;
    read_chk(1'b0, 4'd2, 8'h00, 1'b0, 1'b1, "par_bad");
    release dut16.g_row[2].u_row.q;
    issue(1'b1, 4'd4, 8'h07);
    read_chk(1'b0, 4'd4, 8'h07, 1'b0, 1'b0, "par_clean");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
